// File: rtl/rx_frame_check.sv
// rtl/rx_frame_check.sv - UART receive frame parity and stop-bit checker
// Optional saturating error counter is built only when RX_ERR_CNT_EN is defined.
module rx_frame_check #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  chk_en,
  input  logic                  bit_vld,
  input  logic [3:0]            bit_cnt,
  input  logic                  sampled_bit,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  PAR_EN,
  input  logic [1:0]            PAR_TYP,
  input  logic                  STP_NUM,
  input  logic                  err_clr,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  frame_done,
  output logic [CNT_WIDTH-1:0]  err_cnt
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] PARITY = 2'd1;
  localparam logic [1:0] STOP1  = 2'd2;
  localparam logic [1:0] STOP2  = 2'd3;

  localparam logic [3:0] DATA_IDX = 4'(DATA_WIDTH);
  localparam logic [3:0] PAR_IDX  = 4'(DATA_WIDTH + 1);

  logic [1:0] state;
  logic       par_en_q;
  logic [1:0] par_typ_q;
  logic       stp_num_q;
  logic       par_lat;
  logic       stp_lat;
  logic       exp_par;
  logic [3:0] stop1_idx;
  logic [3:0] stop2_idx;

  always_comb begin
    exp_par = 1'b0;
    case (par_typ_q)
      2'b00:   exp_par = ^P_DATA;
      2'b01:   exp_par = ~^P_DATA;
      2'b10:   exp_par = 1'b1;
      default: exp_par = 1'b0;
    endcase
  end

  // Stop bits follow the parity slot only when parity is present in this frame.
  assign stop1_idx = PAR_IDX + {3'b000, par_en_q};
  assign stop2_idx = stop1_idx + 4'd1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      par_en_q   <= 1'b0;
      par_typ_q  <= 2'b00;
      stp_num_q  <= 1'b0;
      par_lat    <= 1'b0;
      stp_lat    <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (!chk_en) begin
        state <= IDLE;
      end else if (bit_vld) begin
        case (state)
          IDLE: begin
            if (bit_cnt == DATA_IDX) begin
              par_en_q  <= PAR_EN;
              par_typ_q <= PAR_TYP;
              stp_num_q <= STP_NUM;
              par_lat   <= 1'b0;
              stp_lat   <= 1'b0;
              state     <= PAR_EN ? PARITY : STOP1;
            end
          end
          PARITY: begin
            if (bit_cnt == PAR_IDX) begin
              par_lat <= (sampled_bit != exp_par);
              state   <= STOP1;
            end
          end
          STOP1: begin
            if (bit_cnt == stop1_idx) begin
              if (stp_num_q) begin
                stp_lat <= ~sampled_bit;
                state   <= STOP2;
              end else begin
                frame_done <= 1'b1;
                par_err    <= par_lat;
                stp_err    <= ~sampled_bit;
                state      <= IDLE;
              end
            end
          end
          STOP2: begin
            if (bit_cnt == stop2_idx) begin
              frame_done <= 1'b1;
              par_err    <= par_lat;
              stp_err    <= stp_lat | ~sampled_bit;
              state      <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef RX_ERR_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_q;

  // Counts on the frame_done cycle itself, so a coincident err_clr wins.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else if (err_clr) begin
      cnt_q <= '0;
    end else if (frame_done && (par_err || stp_err) && (cnt_q != {CNT_WIDTH{1'b1}})) begin
      cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

  assign err_cnt = cnt_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_cnt        = '0;
`endif

endmodule

// File: tb/tb_rx_frame_check.sv
// tb/tb_rx_frame_check.sv - self-checking bench for rx_frame_check
// Directed frames plus randomized strobes against a frame-level reference model.
module tb_rx_frame_check;

  localparam int DW      = 8;
  localparam int CW      = 2;
  localparam int CNT_MAX = (1 << CW) - 1;
`ifdef RX_ERR_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST;
  logic          chk_en;
  logic          bit_vld;
  logic [3:0]    bit_cnt;
  logic          sampled_bit;
  logic [DW-1:0] P_DATA;
  logic          PAR_EN;
  logic [1:0]    PAR_TYP;
  logic          STP_NUM;
  logic          err_clr;
  logic          par_err;
  logic          stp_err;
  logic          frame_done;
  logic [CW-1:0] err_cnt;

  int n_checks = 0;
  int n_errors = 0;

  bit         m_active, f_par, f_two, m_perr, m_serr, m_done, m_par, m_stp;
  logic [1:0] f_typ;
  int         m_pos;
  int         m_cnt;

  always #5 CLK = ~CLK;

  rx_frame_check #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .CLK(CLK), .RST(RST), .chk_en(chk_en), .bit_vld(bit_vld), .bit_cnt(bit_cnt),
    .sampled_bit(sampled_bit), .P_DATA(P_DATA), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .STP_NUM(STP_NUM), .err_clr(err_clr), .par_err(par_err), .stp_err(stp_err),
    .frame_done(frame_done), .err_cnt(err_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit exp_parity(input logic [1:0] t, input logic [DW-1:0] d);
    case (t)
      2'b00:   return ^d;
      2'b01:   return ~^d;
      2'b10:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Model the frame as a walk over expected bit positions.
  task automatic model_update();
    if (RST) begin
      m_active = 0; m_done = 0; m_par = 0; m_stp = 0; m_cnt = 0;
      return;
    end
    if (CNT_ON) begin
      if (err_clr) m_cnt = 0;
      else if (m_done && (m_par || m_stp) && m_cnt < CNT_MAX) m_cnt++;
    end
    m_done = 0;
    if (!chk_en) begin
      m_active = 0;
    end else if (bit_vld) begin
      if (!m_active) begin
        if (int'(bit_cnt) == DW) begin
          m_active = 1; f_par = PAR_EN; f_typ = PAR_TYP; f_two = STP_NUM;
          m_pos = DW + 1; m_perr = 0; m_serr = 0;
        end
      end else if (int'(bit_cnt) == m_pos) begin
        if (f_par && m_pos == DW + 1) m_perr = (sampled_bit != exp_parity(f_typ, P_DATA));
        else m_serr = m_serr | !sampled_bit;
        if (m_pos == DW + 1 + int'(f_par) + int'(f_two)) begin
          m_active = 0; m_done = 1; m_par = m_perr; m_stp = m_serr;
        end else begin
          m_pos++;
        end
      end
    end
  endtask

  task automatic tick();
    model_update();
    @(posedge CLK);
    #1;
    check_eq("frame_done", frame_done, m_done);
    check_eq("par_err", par_err, m_par);
    check_eq("stp_err", stp_err, m_stp);
    check_eq("err_cnt", err_cnt, m_cnt);
  endtask

  task automatic run_frame(input logic [DW-1:0] d, input bit pe, input logic [1:0] pt,
                           input bit sn, input bit pb, input bit s1, input bit s2,
                           input bit clr, input bit ep, input bit es, input string tag);
    int last;
    last = DW + 1 + int'(pe) + int'(sn);
    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; STP_NUM = sn; chk_en = 1;
    for (int i = 0; i <= last; i++) begin
      bit_vld = 1;
      bit_cnt = 4'(i);
      if (i == 0) sampled_bit = 0;
      else if (i <= DW) sampled_bit = d[i-1];
      else if (pe && i == DW + 1) sampled_bit = pb;
      else if (sn && i == last) sampled_bit = s2;
      else sampled_bit = s1;
      tick();
      bit_vld = 0;
      if (i < last) tick();
    end
    check_eq({tag, "_done"}, frame_done, 1);
    check_eq({tag, "_par"}, par_err, ep);
    check_eq({tag, "_stp"}, stp_err, es);
    err_clr = clr;
    tick();
    err_clr = 0;
    check_eq({tag, "_pulse"}, frame_done, 0);
  endtask

  initial begin
    int idx;
    RST = 1; chk_en = 0; bit_vld = 0; bit_cnt = 0; sampled_bit = 1; P_DATA = 0;
    PAR_EN = 0; PAR_TYP = 0; STP_NUM = 0; err_clr = 0;
    tick(); tick();
    check_eq("rst_done", frame_done, 0);
    check_eq("rst_par", par_err, 0);
    check_eq("rst_stp", stp_err, 0);
    check_eq("rst_cnt", err_cnt, 0);
    RST = 0;
    tick();

    run_frame(8'hA5, 1, 2'b00, 0, 0, 1, 1, 0, 0, 0, "even_ok");
    run_frame(8'hA5, 1, 2'b01, 0, 0, 1, 1, 0, 1, 0, "odd_err");
    check_eq("odd_cnt", err_cnt, CNT_ON ? 1 : 0);
    run_frame(8'h5A, 0, 2'b00, 1, 0, 1, 0, 0, 0, 1, "stop2_err");
    run_frame(8'h0F, 1, 2'b10, 0, 0, 1, 1, 0, 1, 0, "mark_err");
    run_frame(8'hF0, 1, 2'b11, 0, 1, 1, 1, 0, 1, 0, "space_err");
    run_frame(8'hA5, 1, 2'b01, 0, 0, 1, 1, 0, 1, 0, "fifth_err");
    check_eq("sat_cnt", err_cnt, CNT_ON ? 3 : 0);

    // Abort after the parity strobe, then a stray stop strobe must not complete anything.
    P_DATA = 8'h3C; PAR_EN = 1; PAR_TYP = 2'b00; STP_NUM = 0; chk_en = 1;
    for (int i = 0; i <= DW + 1; i++) begin
      bit_vld = 1; bit_cnt = 4'(i); sampled_bit = (i != 0);
      tick();
      bit_vld = 0;
      tick();
    end
    chk_en = 0;
    tick();
    check_eq("abort_done", frame_done, 0);
    check_eq("abort_par", par_err, 1);
    check_eq("abort_stp", stp_err, 0);
    check_eq("abort_cnt", err_cnt, CNT_ON ? 3 : 0);
    chk_en = 1; bit_vld = 1; bit_cnt = 4'(DW + 2); sampled_bit = 1;
    tick();
    check_eq("abort_stray", frame_done, 0);
    bit_vld = 0;
    tick();

    run_frame(8'hA5, 1, 2'b01, 0, 0, 1, 1, 1, 1, 0, "clr_err");
    check_eq("clr_cnt", err_cnt, 0);

    idx = 0;
    for (int c = 0; c < 4000; c++) begin
      RST     = ($urandom_range(0, 199) == 0);
      chk_en  = ($urandom_range(0, 39) != 0);
      err_clr = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 9) == 0) begin
        PAR_EN = 1'($urandom); PAR_TYP = 2'($urandom); STP_NUM = 1'($urandom);
      end
      bit_vld = ($urandom_range(0, 2) == 0);
      if (bit_vld) begin
        if ($urandom_range(0, 11) == 0) begin
          bit_cnt = 4'($urandom);
        end else begin
          bit_cnt = 4'(idx);
          idx = (idx == DW + 3) ? 0 : idx + 1;
        end
        if (int'(bit_cnt) < DW) P_DATA = DW'($urandom);
        sampled_bit = ($urandom_range(0, 3) != 0);
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
